// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch: owns IME (with the EI one-instruction delay), detects
// pending enabled interrupts at instruction boundaries and sequences the
// five M-cycle dispatch: two idle cycles, push PC high, push PC low, jump.
module interrupt_dispatch #(
  parameter int          NUM_INT       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               I_CLOCK,
  input  logic               I_RESET,
  input  logic               I_MCYCLE_STROBE,
  input  logic               I_INSTR_BOUNDARY,
  input  logic [NUM_INT-1:0] I_IF,
  input  logic [NUM_INT-1:0] I_IE,
  input  logic               I_EI,
  input  logic               I_DI,
  input  logic               I_RETI,
  input  logic [15:0]        I_PC,
  input  logic [15:0]        I_SP,
  output logic               O_BUSY,
  output logic [15:0]        O_ADDR,
  output logic [7:0]         O_DATA,
  output logic               O_MEM_WE_L,
  output logic               O_SP_LOAD,
  output logic [15:0]        O_SP_VALUE,
  output logic               O_PC_LOAD,
  output logic [15:0]        O_PC_VALUE,
  output logic               O_IF_LOAD,
  output logic [NUM_INT-1:0] O_IF,
  output logic               O_IME,
  output logic               O_WAKE
);

  typedef enum logic [2:0] {IDLE, WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP} state_t;

  state_t             state_reg, state_next;
  logic               ime_reg, ei_pending_reg;
  logic [15:0]        pc_q, sp_q;
  logic [15:0]        addr_reg, pc_value_reg, sp_value_reg;
  logic [7:0]         data_reg;
  logic [NUM_INT-1:0] clr_mask_reg;
  logic               cancel_reg;

  logic [NUM_INT-1:0] pend_vec;
  logic               pending;
  logic               start_dispatch;
  logic               jump_strobe;

  logic [15:0]        vec_tbl  [NUM_INT];
  logic [NUM_INT-1:0] mask_tbl [NUM_INT];
  logic               sel_found;
  logic [15:0]        sel_vec;
  logic [NUM_INT-1:0] sel_mask;

  assign pend_vec = I_IF & I_IE;
  assign pending  = |pend_vec;

  // Per-source vector address and IF clear mask, fixed at elaboration.
  generate
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_vec
      assign vec_tbl[gi]  = VECTOR_BASE + 16'(VECTOR_STRIDE * gi);
      assign mask_tbl[gi] = NUM_INT'(1) << gi;
    end
  endgenerate

  // Priority pick: lowest set bit of IF & IE wins (descending scan, last hit kept).
  always_comb begin
    sel_found = 1'b0;
    sel_vec   = 16'h0000;
    sel_mask  = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend_vec[i]) begin
        sel_found = 1'b1;
        sel_vec   = vec_tbl[i];
        sel_mask  = mask_tbl[i];
      end
    end
  end

  // Dispatch sequencer state register.
  always_ff @(posedge I_CLOCK or negedge I_RESET) begin
    if (!I_RESET) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state: one step per M-cycle strobe; IME is the registered value, so a
  // boundary that just enabled IME cannot also start a dispatch.
  always_comb begin
    state_next = state_reg;
    if (I_MCYCLE_STROBE) begin
      case (state_reg)
        IDLE:    if (I_INSTR_BOUNDARY && ime_reg && pending) state_next = WAIT0;
        WAIT0:   state_next = WAIT1;
        WAIT1:   state_next = PUSH_HI;
        PUSH_HI: state_next = PUSH_LO;
        PUSH_LO: state_next = JUMP;
        JUMP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign start_dispatch = I_MCYCLE_STROBE && (state_reg == IDLE) && (state_next == WAIT0);

  // IME and the delayed-EI flag; EI/DI/RETI only matter while idle.
  always_ff @(posedge I_CLOCK or negedge I_RESET) begin
    if (!I_RESET) begin
      ime_reg        <= 1'b0;
      ei_pending_reg <= 1'b0;
    end else if (I_MCYCLE_STROBE && (state_reg == IDLE)) begin
      if (start_dispatch || I_DI) begin
        ime_reg        <= 1'b0;
        ei_pending_reg <= 1'b0;
      end else begin
        if (I_RETI) ime_reg <= 1'b1;
        if (I_EI && !ime_reg) begin
          ei_pending_reg <= 1'b1;
        end else if (ei_pending_reg && I_INSTR_BOUNDARY) begin
          ime_reg        <= 1'b1;
          ei_pending_reg <= 1'b0;
        end
      end
    end
  end

  // Dispatch datapath: latch PC/SP, stage push address/data one state ahead,
  // and freeze the vector choice when leaving PUSH_LO.
  always_ff @(posedge I_CLOCK or negedge I_RESET) begin
    if (!I_RESET) begin
      pc_q         <= 16'h0000;
      sp_q         <= 16'h0000;
      addr_reg     <= 16'h0000;
      data_reg     <= 8'h00;
      pc_value_reg <= 16'h0000;
      sp_value_reg <= 16'h0000;
      clr_mask_reg <= '0;
      cancel_reg   <= 1'b0;
    end else if (I_MCYCLE_STROBE) begin
      case (state_reg)
        IDLE: begin
          if (start_dispatch) begin
            pc_q <= I_PC;
            sp_q <= I_SP;
          end
        end
        WAIT1: begin
          addr_reg <= sp_q - 16'd1;
          data_reg <= pc_q[15:8];
        end
        PUSH_HI: begin
          addr_reg <= sp_q - 16'd2;
          data_reg <= pc_q[7:0];
        end
        PUSH_LO: begin
          pc_value_reg <= sel_found ? sel_vec : 16'h0000;
          sp_value_reg <= sp_q - 16'd2;
          clr_mask_reg <= sel_mask;
          cancel_reg   <= !sel_found;
        end
        default: ;
      endcase
    end
  end

  assign jump_strobe = I_MCYCLE_STROBE && (state_reg == JUMP);

  assign O_BUSY     = (state_reg != IDLE);
  assign O_ADDR     = addr_reg;
  assign O_DATA     = data_reg;
  assign O_MEM_WE_L = !(I_MCYCLE_STROBE && ((state_reg == PUSH_HI) || (state_reg == PUSH_LO)));
  assign O_SP_LOAD  = jump_strobe;
  assign O_SP_VALUE = sp_value_reg;
  assign O_PC_LOAD  = jump_strobe;
  assign O_PC_VALUE = pc_value_reg;
  assign O_IF_LOAD  = jump_strobe && !cancel_reg;
  // Live IF is used so a bit that rose during dispatch is written back intact.
  assign O_IF       = ((state_reg == JUMP) && !cancel_reg) ? (I_IF & ~clr_mask_reg) : '0;
  assign O_IME      = ime_reg;
  assign O_WAKE     = pending;

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Directed bench for interrupt_dispatch: one M-cycle strobe every four clocks,
// push/load activity captured during each strobe clock and compared to
// hand-computed values.
module tb_interrupt_dispatch;

  localparam int NUM_INT = 5;

  logic               I_CLOCK, I_RESET, I_MCYCLE_STROBE, I_INSTR_BOUNDARY;
  logic [NUM_INT-1:0] I_IF, I_IE;
  logic               I_EI, I_DI, I_RETI;
  logic [15:0]        I_PC, I_SP;
  logic               O_BUSY, O_MEM_WE_L, O_SP_LOAD, O_PC_LOAD, O_IF_LOAD, O_IME, O_WAKE;
  logic [15:0]        O_ADDR, O_SP_VALUE, O_PC_VALUE;
  logic [7:0]         O_DATA;
  logic [NUM_INT-1:0] O_IF;

  interrupt_dispatch #(.NUM_INT(NUM_INT), .VECTOR_BASE(16'h0040), .VECTOR_STRIDE(8)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_MCYCLE_STROBE(I_MCYCLE_STROBE),
    .I_INSTR_BOUNDARY(I_INSTR_BOUNDARY), .I_IF(I_IF), .I_IE(I_IE),
    .I_EI(I_EI), .I_DI(I_DI), .I_RETI(I_RETI), .I_PC(I_PC), .I_SP(I_SP),
    .O_BUSY(O_BUSY), .O_ADDR(O_ADDR), .O_DATA(O_DATA), .O_MEM_WE_L(O_MEM_WE_L),
    .O_SP_LOAD(O_SP_LOAD), .O_SP_VALUE(O_SP_VALUE), .O_PC_LOAD(O_PC_LOAD),
    .O_PC_VALUE(O_PC_VALUE), .O_IF_LOAD(O_IF_LOAD), .O_IF(O_IF),
    .O_IME(O_IME), .O_WAKE(O_WAKE)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  int          vectors = 0;
  int          miscompares = 0;
  int          strobe_no = 0;
  int          wr_cnt, pc_cnt, sp_cnt, if_cnt, pc_at;
  int          stray = 0;
  logic [15:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  logic [15:0] pc_val, sp_val;
  logic [NUM_INT-1:0] if_val;
  logic        ie_model = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0; pc_cnt = 0; sp_cnt = 0; if_cnt = 0; pc_at = -99;
    pc_val = 16'hDEAD; sp_val = 16'hDEAD; if_val = '1;
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = 16'h0000;
      wr_data[i] = 8'h00;
    end
  endtask

  // One M-cycle: strobe for one clock, capture strobe-clock outputs, then three quiet clocks.
  task automatic mcycle(input logic bnd, input logic ei, input logic di, input logic reti);
    logic       wrote_ie;
    logic [7:0] ie_byte;
    wrote_ie = 1'b0;
    ie_byte  = 8'h00;
    @(posedge I_CLOCK); #1;
    I_MCYCLE_STROBE = 1'b1; I_INSTR_BOUNDARY = bnd; I_EI = ei; I_DI = di; I_RETI = reti;
    strobe_no++;
    @(negedge I_CLOCK);
    if (!O_MEM_WE_L) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = O_ADDR;
        wr_data[wr_cnt] = O_DATA;
      end
      wr_cnt++;
      if (O_ADDR == 16'hFFFF) begin
        wrote_ie = 1'b1;
        ie_byte  = O_DATA;
      end
    end
    if (O_PC_LOAD) begin pc_cnt++; pc_val = O_PC_VALUE; pc_at = strobe_no; end
    if (O_SP_LOAD) begin sp_cnt++; sp_val = O_SP_VALUE; end
    if (O_IF_LOAD) begin if_cnt++; if_val = O_IF; end
    @(posedge I_CLOCK); #1;
    I_MCYCLE_STROBE = 1'b0; I_INSTR_BOUNDARY = 1'b0; I_EI = 1'b0; I_DI = 1'b0; I_RETI = 1'b0;
    if (ie_model && wrote_ie) I_IE = ie_byte[NUM_INT-1:0];
    repeat (3) begin
      @(negedge I_CLOCK);
      if (!O_MEM_WE_L || O_PC_LOAD || O_SP_LOAD || O_IF_LOAD) stray++;
    end
  endtask

  // Boundary strobe (numbered 0) followed by five strobes; the jump lands on strobe 5.
  task automatic run_dispatch(input string tag);
    clear_log();
    strobe_no = -1;
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq({tag, "_busy_start"}, O_BUSY, 1);
    check_eq({tag, "_ime_cleared"}, O_IME, 0);
    repeat (5) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq({tag, "_busy_end"}, O_BUSY, 0);
    check_eq({tag, "_pc_loads"}, pc_cnt, 1);
    check_eq({tag, "_latency"}, pc_at, 5);
    check_eq({tag, "_sp_loads"}, sp_cnt, 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, O_BUSY, 0);
    check_eq({tag, "_we_l"}, O_MEM_WE_L, 1);
    check_eq({tag, "_addr"}, O_ADDR, 0);
    check_eq({tag, "_data"}, O_DATA, 0);
    check_eq({tag, "_sp_load"}, O_SP_LOAD, 0);
    check_eq({tag, "_sp_value"}, O_SP_VALUE, 0);
    check_eq({tag, "_pc_load"}, O_PC_LOAD, 0);
    check_eq({tag, "_pc_value"}, O_PC_VALUE, 0);
    check_eq({tag, "_if_load"}, O_IF_LOAD, 0);
    check_eq({tag, "_if"}, O_IF, 0);
    check_eq({tag, "_ime"}, O_IME, 0);
  endtask

  initial begin
    I_RESET = 1'b0; I_MCYCLE_STROBE = 1'b0; I_INSTR_BOUNDARY = 1'b0;
    I_IF = '0; I_IE = '0; I_EI = 1'b0; I_DI = 1'b0; I_RETI = 1'b0;
    I_PC = 16'h0000; I_SP = 16'h0000;
    clear_log();
    repeat (3) @(negedge I_CLOCK);
    check_reset("rst");
    @(posedge I_CLOCK); #1;
    I_RESET = 1'b1;

    // Basic dispatch: bit 0 wins over bit 2, PC pushed high then low.
    I_IF = 5'b00101; I_IE = 5'b11111; I_PC = 16'h1234; I_SP = 16'hFFFE;
    mcycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t1_ime_reti", O_IME, 1);
    run_dispatch("t1");
    check_eq("t1_wr_cnt", wr_cnt, 2);
    check_eq("t1_wr0_addr", wr_addr[0], 16'hFFFD);
    check_eq("t1_wr0_data", wr_data[0], 8'h12);
    check_eq("t1_wr1_addr", wr_addr[1], 16'hFFFC);
    check_eq("t1_wr1_data", wr_data[1], 8'h34);
    check_eq("t1_pc", pc_val, 16'h0040);
    check_eq("t1_sp", sp_val, 16'hFFFC);
    check_eq("t1_if_loads", if_cnt, 1);
    check_eq("t1_if", if_val, 5'b00100);

    // EI delay: first boundary only enables IME, second dispatches timer.
    I_IF = 5'b00100; I_IE = 5'b00100; I_PC = 16'h2000; I_SP = 16'hD000;
    mcycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t2_ime_after_ei", O_IME, 0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_ime_after_bnd", O_IME, 1);
    check_eq("t2_no_dispatch_yet", O_BUSY, 0);
    run_dispatch("t2");
    check_eq("t2_pc", pc_val, 16'h0050);
    check_eq("t2_sp", sp_val, 16'hCFFE);
    check_eq("t2_wr0_addr", wr_addr[0], 16'hCFFF);
    check_eq("t2_wr0_data", wr_data[0], 8'h20);
    check_eq("t2_if", if_val, 5'b00000);

    // DI together with EI: DI wins, IME stays off across two boundaries.
    mcycle(1'b0, 1'b1, 1'b1, 1'b0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_di_ime_bnd1", O_IME, 0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_di_ime_bnd2", O_IME, 0);
    check_eq("t2_di_busy", O_BUSY, 0);

    // SP wraps to 0xFFFF; the high push lands in IE and steers selection.
    ie_model = 1'b1;
    I_IF = 5'b00001; I_IE = 5'b00001; I_PC = 16'hABCD; I_SP = 16'h0000;
    mcycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_dispatch("t3a");
    check_eq("t3a_wr0_addr", wr_addr[0], 16'hFFFF);
    check_eq("t3a_wr0_data", wr_data[0], 8'hAB);
    check_eq("t3a_wr1_addr", wr_addr[1], 16'hFFFE);
    check_eq("t3a_wr1_data", wr_data[1], 8'hCD);
    check_eq("t3a_pc", pc_val, 16'h0040);
    check_eq("t3a_sp", sp_val, 16'hFFFE);
    check_eq("t3a_if", if_val, 5'b00000);
    I_IE = 5'b00001; I_PC = 16'hA0CD;
    mcycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_dispatch("t3b");
    check_eq("t3b_pc_cancel", pc_val, 16'h0000);
    check_eq("t3b_if_loads", if_cnt, 0);
    check_eq("t3b_sp", sp_val, 16'hFFFE);
    ie_model = 1'b0;

    // IME off: wake follows IF & IE but nothing dispatches.
    I_IF = 5'b10000; I_IE = 5'b10000;
    #1;
    check_eq("t4_wake", O_WAKE, 1);
    clear_log();
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_busy", O_BUSY, 0);
    check_eq("t4_wr_cnt", wr_cnt, 0);
    I_IE = 5'b01111;
    #1;
    check_eq("t4_wake_masked", O_WAKE, 0);

    // Reset while in PUSH_LO aborts at once.
    I_IF = 5'b00001; I_IE = 5'b00001; I_PC = 16'h5566; I_SP = 16'h8000;
    mcycle(1'b0, 1'b0, 1'b0, 1'b1);
    clear_log();
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t5_addr_pushlo", O_ADDR, 16'h7FFE);
    check_eq("t5_busy_pushlo", O_BUSY, 1);
    #2 I_RESET = 1'b0;
    #1 check_reset("t5");
    repeat (2) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge I_CLOCK); #1;
    I_RESET = 1'b1;
    mcycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t5_pc_loads", pc_cnt, 0);
    check_eq("t5_wr_cnt", wr_cnt, 1);
    check_eq("t5_busy_after", O_BUSY, 0);

    // RETI enables IME at once; next boundary dispatches serial.
    I_IF = 5'b01000; I_IE = 5'b01000; I_PC = 16'h0150; I_SP = 16'hC000;
    mcycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_ime", O_IME, 1);
    run_dispatch("t6");
    check_eq("t6_pc", pc_val, 16'h0058);
    check_eq("t6_sp", sp_val, 16'hBFFE);
    check_eq("t6_if", if_val, 5'b00000);

    check_eq("stray_activity", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
